// File: rtl/point_cloud_server.sv
// Point-cloud store and RANSAC point-fetch responder.
// Latency: read_latency cycles from accepted request to point_data_valid (RAM output register included).
// Backpressure: load stream stalls (load_ready=0) once a cloud is held; reads have no backpressure.
//
// Ports:
//   clock, reset (async, active-high), clear (sync flush back to IDLE)
//   load_valid/load_ready/load_point/load_last : cloud load stream
//   point_addr_valid/point_addr                : read requests, honoured only while cloud_ready
//   point_data_valid/point_out                 : in-order read responses
//   point_count  : index of the last stored point
//   cloud_ready  : cloud loaded, reads served
//   addr_error   : sticky out-of-range read flag (updates the cycle after the offending response)
//   read_count   : served-read counter, built only with POINT_CLOUD_SERVER_READ_COUNT_EN defined

package ransac_fixed;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } point_t;
endpackage

module point_cloud_server #(
  parameter int point_addr_width = 9,
  parameter int read_latency     = 2   // legal range 1..4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  ransac_fixed::point_t          load_point,
  input  logic                          load_last,
  input  logic                          point_addr_valid,
  input  logic [point_addr_width-1:0]   point_addr,
  output logic                          point_data_valid,
  output ransac_fixed::point_t          point_out,
  output logic [point_addr_width-1:0]   point_count,
  output logic                          cloud_ready,
  output logic                          addr_error,
  output logic [31:0]                   read_count
);

  localparam int DEPTH = 2 ** point_addr_width;
  localparam logic [point_addr_width-1:0] PTR_MAX = {point_addr_width{1'b1}};

  typedef enum logic [1:0] {IDLE, LOADING, SERVING} state_t;

  state_t state, next_state;

  logic [point_addr_width-1:0] wr_ptr;
  logic                        load_beat;
  logic                        load_end;
  logic                        rd_acc;

  ransac_fixed::point_t mem [0:DEPTH-1];
  ransac_fixed::point_t resp_src;

  // chain[0] is the request being accepted this cycle, chain[read_latency] the visible response
  logic [read_latency-1:0] vld_pipe;
  logic [read_latency-1:0] oor_pipe;
  logic [read_latency:0]   vld_chain;
  logic [read_latency:0]   oor_chain;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_beat  = 1'b0;
    load_end   = 1'b0;
    unique case (state)
      IDLE, LOADING: begin
        load_beat = load_valid && load_ready;
        // The top slot filling up ends the cloud even without load_last.
        load_end  = load_beat && (load_last || (wr_ptr == PTR_MAX));
        if (load_end)       next_state = SERVING;
        else if (load_beat) next_state = LOADING;
      end
      SERVING: next_state = SERVING;
      default: next_state = IDLE;
    endcase
    if (clear) begin
      next_state = IDLE;
      load_beat  = 1'b0;
      load_end   = 1'b0;
    end
  end

  assign cloud_ready = (state == SERVING);

  // ---------------------------------------------------------------- load side
  // load_ready is registered from next_state so it reads 0 during reset and
  // drops on the very edge that accepts the final beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      point_count <= '0;
      load_ready  <= 1'b0;
    end else begin
      load_ready <= (next_state != SERVING);
      if (clear) begin
        wr_ptr      <= '0;
        point_count <= '0;
      end else if (load_beat) begin
        wr_ptr <= wr_ptr + point_addr_width'(1);
        if (load_end) point_count <= wr_ptr;
      end
    end
  end

  // Write port; contents survive clear and reset.
  always_ff @(posedge clock) begin
    if (load_beat) mem[wr_ptr] <= load_point;
  end

  // ---------------------------------------------------------------- read side
  assign rd_acc       = point_addr_valid && cloud_ready && !clear;
  assign vld_chain[0] = rd_acc;
  assign oor_chain[0] = rd_acc && (point_addr > point_count);
  assign vld_chain[read_latency:1] = vld_pipe;
  assign oor_chain[read_latency:1] = oor_pipe;
  assign point_data_valid = vld_chain[read_latency];

  generate
    if (read_latency == 1) begin : g_lat1
      // point_out itself acts as the RAM output register.
      assign resp_src = mem[point_addr];
    end else begin : g_latn
      ransac_fixed::point_t dly [1:read_latency-1];
      always_ff @(posedge clock) begin
        dly[1] <= mem[point_addr];
        for (int i = 2; i < read_latency; i++) dly[i] <= dly[i-1];
      end
      assign resp_src = dly[read_latency-1];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      oor_pipe   <= '0;
      point_out  <= '0;
      addr_error <= 1'b0;
    end else if (clear) begin
      vld_pipe   <= '0;
      oor_pipe   <= '0;
      addr_error <= 1'b0;
    end else begin
      vld_pipe <= vld_chain[read_latency-1:0];
      oor_pipe <= oor_chain[read_latency-1:0];
      // Data only moves on a response so point_out holds between them.
      if (vld_chain[read_latency-1])
        point_out <= oor_chain[read_latency-1] ? '0 : resp_src;
      if (vld_chain[read_latency] && oor_chain[read_latency])
        addr_error <= 1'b1;
    end
  end

`ifdef POINT_CLOUD_SERVER_READ_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                           read_count <= '0;
    else if (clear)                                      read_count <= '0;
    else if (point_data_valid && (read_count != '1))     read_count <= read_count + 32'd1;
  end
`else
  assign read_count = '0;
`endif

endmodule
